// File: rtl/regfile_update_arb_pkg.sv
// Shared constants for the register-file update arbiter: the None tag, default tag width,
// register-file mode encodings and the per-cycle grant outcome.
package regfile_update_arb_pkg;

    localparam int TAG_W_DEFAULT = 4;
    localparam int TAG_NONE      = 0;

    localparam logic RF_MODE_FOQ = 1'b0;
    localparam logic RF_MODE_ROB = 1'b1;

    localparam int RF_DATA_W = 32;
    localparam int RF_RD_W   = 5;

    typedef enum logic [1:0] {
        GRANT_IDLE = 2'd0,
        GRANT_ISS  = 2'd1,
        GRANT_CMT  = 2'd2
    } grant_e;

endpackage

// File: rtl/regfile_update_arb_commit_fifo.sv
// commit_fifo: synchronous FIFO with push/pop, full/empty and occupancy; state moves only
// when rdy_in is high, and an active-low synchronous reset empties it.
module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        do_push = rdy_in && push && !full;
        do_pop  = rdy_in && pop && !empty;
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = do_push && (wr_ptr_q == PTR_W'(gi));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_q[i] <= push_data;
            end
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/regfile_update_arb.sv
// Single update-port arbiter for the rename register file: ROB commits buffered in a FIFO
// versus issue renames, with bounded issue starvation. Optional REGFILE_ARB_BYPASS_EN lets a
// commit skip the empty FIFO and reach rf_* one cycle after acceptance.
module regfile_update_arb
    import regfile_update_arb_pkg::*;
#(
    parameter int COMMIT_DEPTH = 4,
    parameter int TAG_W        = TAG_W_DEFAULT,
    parameter int STARVE_MAX   = 3,
    localparam int CNT_W       = $clog2(COMMIT_DEPTH) + 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [RF_RD_W-1:0]   iss_rd,
    input  logic [TAG_W-1:0]     iss_tag,
    input  logic                 cmt_valid,
    output logic                 cmt_ready,
    input  logic [TAG_W-1:0]     cmt_tag,
    input  logic [RF_DATA_W-1:0] cmt_data,
    output logic                 rf_mode,
    output logic [RF_RD_W-1:0]   rf_rd,
    output logic [TAG_W-1:0]     rf_foq_depend,
    output logic [RF_DATA_W-1:0] rf_rob_data,
    output logic [TAG_W-1:0]     rf_rob_depend,
    output logic [CNT_W-1:0]     cmt_count
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int ENTRY_W  = TAG_W + RF_DATA_W;

    logic [ENTRY_W-1:0]   fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [CNT_W-1:0]     fifo_count;

    logic                 tag_live;
    logic                 cmt_accept;
    logic                 bypass_cand;
    logic                 use_bypass;
    logic                 cmt_avail;
    logic                 cmt_prio;
    grant_e               grant;

    logic [TAG_W-1:0]     win_tag;
    logic [RF_DATA_W-1:0] win_data;

    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 rf_mode_q, rf_mode_d;
    logic [RF_RD_W-1:0]   rf_rd_q, rf_rd_d;
    logic [TAG_W-1:0]     rf_foq_depend_q, rf_foq_depend_d;
    logic [RF_DATA_W-1:0] rf_rob_data_q, rf_rob_data_d;
    logic [TAG_W-1:0]     rf_rob_depend_q, rf_rob_depend_d;

    commit_fifo #(
        .DEPTH (COMMIT_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_commit_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .push      (fifo_push),
        .push_data ({cmt_tag, cmt_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        tag_live   = (cmt_tag != TAG_W'(TAG_NONE));
        cmt_ready  = rst_in && rdy_in && !fifo_full;
        cmt_accept = cmt_valid && cmt_ready;
`ifdef REGFILE_ARB_BYPASS_EN
        bypass_cand = fifo_empty && cmt_accept && tag_live;
`else
        bypass_cand = 1'b0;
`endif
        cmt_avail = !fifo_empty || bypass_cand;
        cmt_prio  = (starve_q < STARVE_W'(STARVE_MAX));

        // Issue readiness must not look at iss_valid, so it is derived from the commit side only.
        iss_ready = rst_in && rdy_in && (!cmt_avail || !cmt_prio);

        if (cmt_avail && (cmt_prio || !iss_valid)) begin
            grant = GRANT_CMT;
        end else if (iss_valid) begin
            grant = GRANT_ISS;
        end else begin
            grant = GRANT_IDLE;
        end

        // A bypass candidate that loses arbitration still has to be buffered.
        use_bypass = bypass_cand && (grant == GRANT_CMT);
        fifo_push  = cmt_accept && tag_live && !use_bypass;
        fifo_pop   = (grant == GRANT_CMT) && !fifo_empty;

        if (use_bypass) begin
            win_tag  = cmt_tag;
            win_data = cmt_data;
        end else begin
            win_tag  = fifo_head[ENTRY_W-1:RF_DATA_W];
            win_data = fifo_head[RF_DATA_W-1:0];
        end
    end

    always_comb begin
        starve_d        = starve_q;
        rf_mode_d       = rf_mode_q;
        rf_rd_d         = rf_rd_q;
        rf_foq_depend_d = rf_foq_depend_q;
        rf_rob_data_d   = rf_rob_data_q;
        rf_rob_depend_d = rf_rob_depend_q;

        if (rdy_in) begin
            if (iss_valid && (grant != GRANT_ISS)) begin
                if (starve_q != STARVE_W'(STARVE_MAX)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end else begin
                starve_d = '0;
            end

            case (grant)
                GRANT_CMT: begin
                    rf_mode_d       = RF_MODE_ROB;
                    rf_rob_depend_d = win_tag;
                    rf_rob_data_d   = win_data;
                end
                GRANT_ISS: begin
                    rf_mode_d       = RF_MODE_FOQ;
                    rf_rd_d         = iss_rd;
                    rf_foq_depend_d = iss_tag;
                end
                default: begin
                    // rd=0 is a no-op for the register file, which makes idle cycles safe.
                    rf_mode_d = RF_MODE_FOQ;
                    rf_rd_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            starve_q        <= '0;
            rf_mode_q       <= RF_MODE_FOQ;
            rf_rd_q         <= '0;
            rf_foq_depend_q <= '0;
            rf_rob_data_q   <= '0;
            rf_rob_depend_q <= '0;
        end else begin
            starve_q        <= starve_d;
            rf_mode_q       <= rf_mode_d;
            rf_rd_q         <= rf_rd_d;
            rf_foq_depend_q <= rf_foq_depend_d;
            rf_rob_data_q   <= rf_rob_data_d;
            rf_rob_depend_q <= rf_rob_depend_d;
        end
    end

    assign rf_mode       = rf_mode_q;
    assign rf_rd         = rf_rd_q;
    assign rf_foq_depend = rf_foq_depend_q;
    assign rf_rob_data   = rf_rob_data_q;
    assign rf_rob_depend = rf_rob_depend_q;
    assign cmt_count     = fifo_count;

endmodule

// File: tb/tb_regfile_update_arb.sv
// Directed self-checking bench for regfile_update_arb (default build, FIFO path for commits).
module tb_regfile_update_arb;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [3:0]  iss_tag;
    logic        cmt_valid;
    logic        cmt_ready;
    logic [3:0]  cmt_tag;
    logic [31:0] cmt_data;
    logic        rf_mode;
    logic [4:0]  rf_rd;
    logic [3:0]  rf_foq_depend;
    logic [31:0] rf_rob_data;
    logic [3:0]  rf_rob_depend;
    logic [2:0]  cmt_count;

    int checks;
    int failures;

    regfile_update_arb #(
        .COMMIT_DEPTH (4),
        .TAG_W        (4),
        .STARVE_MAX   (3)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_rd        (iss_rd),
        .iss_tag       (iss_tag),
        .cmt_valid     (cmt_valid),
        .cmt_ready     (cmt_ready),
        .cmt_tag       (cmt_tag),
        .cmt_data      (cmt_data),
        .rf_mode       (rf_mode),
        .rf_rd         (rf_rd),
        .rf_foq_depend (rf_foq_depend),
        .rf_rob_data   (rf_rob_data),
        .rf_rob_depend (rf_rob_depend),
        .cmt_count     (cmt_count)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1;
        iss_valid = 1'b0; iss_rd = 5'd0; iss_tag = 4'd0;
        cmt_valid = 1'b0; cmt_tag = 4'd0; cmt_data = 32'd0;
        tick(); tick();
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL rst_iss_ready got=%0h exp=0", iss_ready); end
        checks++; if (cmt_ready !== 1'b0) begin failures++; $display("FAIL rst_cmt_ready got=%0h exp=0", cmt_ready); end
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL rst_rf_mode got=%0h exp=0", rf_mode); end
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL rst_rf_rd got=%0h exp=0", rf_rd); end
        checks++; if (rf_foq_depend !== 4'd0) begin failures++; $display("FAIL rst_foq got=%0h exp=0", rf_foq_depend); end
        checks++; if (rf_rob_data !== 32'd0) begin failures++; $display("FAIL rst_rob_data got=%0h exp=0", rf_rob_data); end
        checks++; if (rf_rob_depend !== 4'd0) begin failures++; $display("FAIL rst_rob_dep got=%0h exp=0", rf_rob_depend); end
        checks++; if (cmt_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0h exp=0", cmt_count); end
        rst_in = 1'b1;
        repeat (3) tick();
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL idle_rf_mode got=%0h exp=0", rf_mode); end
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL idle_rf_rd got=%0h exp=0", rf_rd); end
        checks++; if (cmt_count !== 3'd0) begin failures++; $display("FAIL idle_count got=%0h exp=0", cmt_count); end
        checks++; if (cmt_ready !== 1'b1) begin failures++; $display("FAIL idle_cmt_ready got=%0h exp=1", cmt_ready); end
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL idle_iss_ready got=%0h exp=1", iss_ready); end
        $display("tb: reset and 3 idle cycles");
    endtask

    task automatic test_issue();
        iss_valid = 1'b1; iss_rd = 5'd5; iss_tag = 4'd3;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL iss_ready got=%0h exp=1", iss_ready); end
        tick();
        iss_valid = 1'b0;
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL iss_mode got=%0h exp=0", rf_mode); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL iss_rd got=%0h exp=5", rf_rd); end
        checks++; if (rf_foq_depend !== 4'd3) begin failures++; $display("FAIL iss_foq got=%0h exp=3", rf_foq_depend); end
        tick();
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL iss_after_rd got=%0h exp=0", rf_rd); end
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL iss_after_mode got=%0h exp=0", rf_mode); end
        $display("tb: issue rd=5 tag=3");
        iss_valid = 1'b1; iss_rd = 5'd0; iss_tag = 4'd6;
        tick();
        iss_valid = 1'b0;
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL iss_rd0_rd got=%0h exp=0", rf_rd); end
        checks++; if (rf_foq_depend !== 4'd6) begin failures++; $display("FAIL iss_rd0_foq got=%0h exp=6", rf_foq_depend); end
        tick();
        $display("tb: issue rd=0 tag=6");
    endtask

    task automatic test_commit_latency();
        cmt_valid = 1'b1; cmt_tag = 4'd3; cmt_data = 32'hDEADBEEF;
        #1;
        checks++; if (cmt_ready !== 1'b1) begin failures++; $display("FAIL lat_cmt_ready got=%0h exp=1", cmt_ready); end
        tick();
        cmt_valid = 1'b0;
        checks++; if (cmt_count !== 3'd1) begin failures++; $display("FAIL lat_count1 got=%0h exp=1", cmt_count); end
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL lat_mode_t1 got=%0h exp=0", rf_mode); end
        tick();
        checks++; if (rf_mode !== 1'b1) begin failures++; $display("FAIL lat_mode_t2 got=%0h exp=1", rf_mode); end
        checks++; if (rf_rob_depend !== 4'd3) begin failures++; $display("FAIL lat_dep got=%0h exp=3", rf_rob_depend); end
        checks++; if (rf_rob_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lat_data got=%0h exp=deadbeef", rf_rob_data); end
        checks++; if (cmt_count !== 3'd0) begin failures++; $display("FAIL lat_count0 got=%0h exp=0", cmt_count); end
        tick();
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL lat_mode_t3 got=%0h exp=0", rf_mode); end
        $display("tb: commit tag=3 data=deadbeef");
    endtask

    task automatic test_starvation();
        iss_valid = 1'b1; iss_rd = 5'd7; iss_tag = 4'd9;
        cmt_valid = 1'b1; cmt_tag = 4'd1; cmt_data = 32'h101;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL stv_ready_e0 got=%0h exp=1", iss_ready); end
        tick();
        checks++; if (rf_mode !== 1'b0 || rf_rd !== 5'd7) begin failures++; $display("FAIL stv_e0 got=%0h/%0h exp=0/7", rf_mode, rf_rd); end
        checks++; if (cmt_count !== 3'd1) begin failures++; $display("FAIL stv_count_e0 got=%0h exp=1", cmt_count); end
        cmt_tag = 4'd2; cmt_data = 32'h102;
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL stv_ready_e1 got=%0h exp=0", iss_ready); end
        tick();
        checks++; if (rf_mode !== 1'b1 || rf_rob_depend !== 4'd1) begin failures++; $display("FAIL stv_e1 got=%0h/%0h exp=1/1", rf_mode, rf_rob_depend); end
        cmt_tag = 4'd3; cmt_data = 32'h103;
        tick();
        checks++; if (rf_rob_depend !== 4'd2) begin failures++; $display("FAIL stv_e2 got=%0h exp=2", rf_rob_depend); end
        cmt_tag = 4'd4; cmt_data = 32'h104;
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL stv_ready_e3 got=%0h exp=0", iss_ready); end
        tick();
        checks++; if (rf_rob_depend !== 4'd3) begin failures++; $display("FAIL stv_e3 got=%0h exp=3", rf_rob_depend); end
        cmt_valid = 1'b0;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL stv_ready_e4 got=%0h exp=1", iss_ready); end
        tick();
        checks++; if (rf_mode !== 1'b0 || rf_rd !== 5'd7) begin failures++; $display("FAIL stv_e4_forced got=%0h/%0h exp=0/7", rf_mode, rf_rd); end
        checks++; if (cmt_count !== 3'd1) begin failures++; $display("FAIL stv_count_e4 got=%0h exp=1", cmt_count); end
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL stv_ready_e5 got=%0h exp=0", iss_ready); end
        tick();
        checks++; if (rf_mode !== 1'b1 || rf_rob_depend !== 4'd4) begin failures++; $display("FAIL stv_e5 got=%0h/%0h exp=1/4", rf_mode, rf_rob_depend); end
        checks++; if (rf_rob_data !== 32'h104) begin failures++; $display("FAIL stv_e5_data got=%0h exp=104", rf_rob_data); end
        tick();
        checks++; if (rf_mode !== 1'b0 || rf_rd !== 5'd7) begin failures++; $display("FAIL stv_e6 got=%0h/%0h exp=0/7", rf_mode, rf_rd); end
        iss_valid = 1'b0;
        tick();
        $display("tb: starvation, forced issue after 3 lost cycles");
    endtask

    task automatic test_full();
        iss_valid = 1'b1; iss_rd = 5'd2; iss_tag = 4'd8;
        for (int i = 0; i < 14; i++) begin
            cmt_valid = 1'b1;
            cmt_tag   = 4'((i % 7) + 1);
            cmt_data  = 32'h200 + 32'(i);
            #1;
            if (i == 12) begin
                checks++; if (cmt_ready !== 1'b1) begin failures++; $display("FAIL full_ready_pre got=%0h exp=1", cmt_ready); end
            end
            if (i == 13) begin
                checks++; if (cmt_count !== 3'd4) begin failures++; $display("FAIL full_count4 got=%0h exp=4", cmt_count); end
                checks++; if (cmt_ready !== 1'b0) begin failures++; $display("FAIL full_cmt_ready got=%0h exp=0", cmt_ready); end
                checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL full_iss_ready got=%0h exp=0", iss_ready); end
            end
            tick();
        end
        cmt_valid = 1'b0; iss_valid = 1'b0;
        checks++; if (cmt_count !== 3'd3) begin failures++; $display("FAIL full_push_refused got=%0h exp=3", cmt_count); end
        checks++; if (rf_rob_depend !== 4'd3) begin failures++; $display("FAIL full_pop_e13 got=%0h exp=3", rf_rob_depend); end
        tick();
        checks++; if (rf_rob_depend !== 4'd4) begin failures++; $display("FAIL full_drain0 got=%0h exp=4", rf_rob_depend); end
        tick();
        checks++; if (rf_rob_depend !== 4'd5) begin failures++; $display("FAIL full_drain1 got=%0h exp=5", rf_rob_depend); end
        tick();
        checks++; if (rf_rob_depend !== 4'd6 || rf_rob_data !== 32'h20C) begin failures++; $display("FAIL full_drain2 got=%0h/%0h exp=6/20c", rf_rob_depend, rf_rob_data); end
        checks++; if (cmt_count !== 3'd0) begin failures++; $display("FAIL full_drained got=%0h exp=0", cmt_count); end
        tick();
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL full_no_extra got=%0h exp=0", rf_mode); end
        $display("tb: fill FIFO to 4, refused push, drain");
    endtask

    task automatic test_tag0();
        cmt_valid = 1'b1; cmt_tag = 4'd0; cmt_data = 32'h55;
        #1;
        checks++; if (cmt_ready !== 1'b1) begin failures++; $display("FAIL tag0_ready got=%0h exp=1", cmt_ready); end
        tick();
        cmt_valid = 1'b0;
        checks++; if (cmt_count !== 3'd0) begin failures++; $display("FAIL tag0_count got=%0h exp=0", cmt_count); end
        tick();
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL tag0_mode got=%0h exp=0", rf_mode); end
        $display("tb: commit tag=0 discarded");
    endtask

    task automatic test_pause();
        cmt_valid = 1'b1; cmt_tag = 4'hA; cmt_data = 32'hA0A;
        tick();
        cmt_tag = 4'hB; cmt_data = 32'hB0B;
        tick();
        checks++; if (rf_mode !== 1'b1 || rf_rob_depend !== 4'hA) begin failures++; $display("FAIL pause_pre got=%0h/%0h exp=1/a", rf_mode, rf_rob_depend); end
        rdy_in = 1'b0; cmt_tag = 4'hC; iss_valid = 1'b1; iss_rd = 5'd9;
        #1;
        checks++; if (cmt_ready !== 1'b0) begin failures++; $display("FAIL pause_cmt_ready got=%0h exp=0", cmt_ready); end
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL pause_iss_ready got=%0h exp=0", iss_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (rf_mode !== 1'b1 || rf_rob_depend !== 4'hA || rf_rob_data !== 32'hA0A) begin failures++; $display("FAIL pause_hold%0d got=%0h/%0h/%0h exp=1/a/a0a", i, rf_mode, rf_rob_depend, rf_rob_data); end
            checks++; if (cmt_count !== 3'd1) begin failures++; $display("FAIL pause_count%0d got=%0h exp=1", i, cmt_count); end
        end
        rdy_in = 1'b1; cmt_valid = 1'b0; iss_valid = 1'b0;
        tick();
        checks++; if (rf_mode !== 1'b1 || rf_rob_depend !== 4'hB || rf_rob_data !== 32'hB0B) begin failures++; $display("FAIL pause_resume got=%0h/%0h/%0h exp=1/b/b0b", rf_mode, rf_rob_depend, rf_rob_data); end
        checks++; if (cmt_count !== 3'd0) begin failures++; $display("FAIL pause_resume_count got=%0h exp=0", cmt_count); end
        tick();
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL pause_end got=%0h exp=0", rf_mode); end
        $display("tb: rdy_in low 2 cycles mid-stream");
    endtask

    task automatic test_reset_mid();
        cmt_valid = 1'b1; cmt_tag = 4'd5; cmt_data = 32'h5555;
        tick();
        cmt_valid = 1'b0;
        checks++; if (cmt_count !== 3'd1) begin failures++; $display("FAIL rmid_pre got=%0h exp=1", cmt_count); end
        rst_in = 1'b0;
        tick();
        checks++; if (cmt_count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0h exp=0", cmt_count); end
        checks++; if (rf_rob_depend !== 4'd0 || rf_rob_data !== 32'd0) begin failures++; $display("FAIL rmid_rob got=%0h/%0h exp=0/0", rf_rob_depend, rf_rob_data); end
        checks++; if (cmt_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%0h exp=0", cmt_ready); end
        rst_in = 1'b1;
        tick();
        checks++; if (rf_mode !== 1'b0) begin failures++; $display("FAIL rmid_mode0 got=%0h exp=0", rf_mode); end
        tick();
        checks++; if (rf_mode !== 1'b0 || cmt_count !== 3'd0) begin failures++; $display("FAIL rmid_dropped got=%0h/%0h exp=0/0", rf_mode, cmt_count); end
        $display("tb: reset mid-operation drops FIFO");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_issue();
        test_commit_latency();
        test_starvation();
        test_full();
        test_tag0();
        test_pause();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_update_arb.md
# regfile_update_arb

Arbiter and sequencer for the rename register file's single update port. The register file applies exactly one update per cycle: either an issue-side rename (mode 0: `depend_file[rd] <= tag`) or a ROB broadcast (mode 1: every register whose dependency equals the tag takes the data and clears to None). This block sits between the issue queue and the ROB on one side and the register file on the other. It buffers ROB commits in a small FIFO, arbitrates them against issue renames with bounded starvation, and drives registered, idle-safe controls into the register file.

## Interface
Parameters:
- `COMMIT_DEPTH`, 4: commit FIFO entries; power of two, ≥2.
- `TAG_W`, 4: ROB tag width. Tag 0 is `None`.
- `STARVE_MAX`, 3: consecutive lost issue cycles before issue is force-granted.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, synchronous, active-low.
- `rdy_in` in 1: global ready; low = pause.
- `iss_valid` in 1: rename request.
- `iss_ready` out 1: rename accepted this cycle.
- `iss_rd` in 5: destination register.
- `iss_tag` in TAG_W: new dependency tag.
- `cmt_valid` in 1: ROB commit.
- `cmt_ready` out 1: commit accepted.
- `cmt_tag` in TAG_W: committing tag.
- `cmt_data` in 32: result value.
- `rf_mode` out 1: 0 = rename/idle, 1 = ROB update.
- `rf_rd` out 5: register-file rd.
- `rf_foq_depend` out TAG_W: rename tag.
- `rf_rob_data` out 32: broadcast data.
- `rf_rob_depend` out TAG_W: broadcast tag.
- `cmt_count` out $clog2(COMMIT_DEPTH)+1: FIFO occupancy.

## Operation
- All state changes occur only when `rst_in`=1 and `rdy_in`=1.
- `cmt_ready` = `rdy_in` && FIFO not full. `cmt_valid` && `cmt_ready` pushes {tag, data}.
- A commit with `cmt_tag` = 0 is accepted and discarded, and never pushed.
- Grant decision each cycle, evaluated in this order:
  1. Commit wins if a commit is available (FIFO head, or bypass candidate) and (`starve_cnt` < `STARVE_MAX` or `iss_valid`=0).
  2. Otherwise issue wins if `iss_valid`=1.
  3. Otherwise the cycle is idle.
- `iss_ready` = `rdy_in` && issue wins. It is combinational from FIFO state and `starve_cnt`, not from `iss_valid`.
- `starve_cnt` behaviour:
  - +1, saturating, when `iss_valid`=1 and issue loses.
  - Cleared when issue wins or `iss_valid`=0.
- Output register loading on each cycle with `rdy_in`=1:
  - Commit win: mode=1, rob_depend/rob_data = head, pop.
  - Issue win: mode=0, rd=`iss_rd`, foq_depend=`iss_tag`.
  - Idle: mode=0, rd=0. The register file treats rd=0 as a no-op.
- Issue with `iss_rd`=0 is accepted and produces a no-op output.
- Simultaneous push and pop on a full FIFO: the push is refused, because `cmt_ready` is already low.
- Simultaneous push and pop on a non-full FIFO: occupancy is unchanged.

## Timing
- Reset values:
  - `rf_mode`=0, `rf_rd`=0, `rf_foq_depend`=0, `rf_rob_data`=0, `rf_rob_depend`=0.
  - `iss_ready`=0, `cmt_ready`=0, `cmt_count`=0.
  - FIFO empty, `starve_cnt`=0.
- Issue latency: accepted at edge T, `rf_*` valid during cycle T+1, register file writes at edge T+2.
- Commit latency without bypass: pushed at T, head at T+1, granted at T+1, `rf_*` during T+2.
- `rdy_in`=0: both readies low, FIFO, `starve_cnt` and `rf_*` hold.
- Reset asserted mid-operation: next edge restores reset values and drops FIFO contents.
- FIFO pointers wrap modulo `COMMIT_DEPTH`. Occupancy uses an extra bit, so full and empty are distinguishable.
- Worst-case issue wait is `STARVE_MAX` cycles. After a forced issue grant, a pending commit wins the next cycle.

## Configuration
- `REGFILE_ARB_BYPASS_EN` defined:
  - When the FIFO is empty and commit wins via the input, the `cmt_*` values load directly into `rf_*` without a push.
  - Commit latency becomes 1 cycle, the same as issue.
- Undefined: every commit goes through the FIFO, with 2-cycle minimum latency.
- Grant fairness is identical in both builds.

## Structure
- The shared macros header holds:
  - The `None` tag value (0).
  - `TAG_W` default.
  - Mode encodings `RF_MODE_FOQ`=0 and `RF_MODE_ROB`=1.
- One sub-module, `commit_fifo`: a parameterized synchronous FIFO with push/pop, full/empty and count. Same reset and `rdy_in` semantics as this block.

## Test plan
- Reset, then idle 3 cycles → all `rf_*`=0, `cmt_count`=0, `cmt_ready`=1.
- Issue rd=5, tag=3 alone → `rf_mode`=0, `rf_rd`=5, `rf_foq_depend`=3 one cycle later, then rd=0.
- Commit tag=3, data=0xDEADBEEF with bypass off → `rf_mode`=1, `rf_rob_depend`=3, `rf_rob_data`=0xDEADBEEF two cycles after accept. With bypass on, one cycle after accept.
- Push 4 commits while issue is held valid → issue granted on the 4th cycle (`STARVE_MAX`=3), then commits resume. `cmt_ready`=0 while `cmt_count`=4.
- Commit with tag 0 → accepted, `cmt_count` unchanged, no mode-1 output.
- `rdy_in` low for 2 cycles mid-stream → outputs and occupancy frozen. Resume yields the identical sequence.
